// File: rtl/score_pkg.sv
// Shared types and defaults for the score counter slice.
package score_pkg;
    localparam int SCORE_W               = 7;
    localparam int FCNT_W                = 6;
    localparam int DEF_MAX_SCORE         = 99;
    localparam int DEF_HOLD_DELAY_FRAMES = 15;
    localparam int DEF_REPEAT_FRAMES     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_FROZEN
    } score_state_t;
endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw move button plus a rise-edge detector.
module btn_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    logic meta;
    logic level;
    logic level_q;
    logic primed;
    logic armed;

    // A button held through reset must be seen released before a rise counts;
    // primed marks the first cycle where meta holds a real sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta    <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            primed  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            meta    <= i_btn;
            level   <= meta;
            level_q <= level;
            primed  <= 1'b1;
            armed   <= armed | (primed & ~meta);
        end
    end

    assign o_level = level;
    assign o_rise  = level & ~level_q & armed;
endmodule

// File: rtl/score_counter.sv
// Move-button score counter with hold auto-repeat, saturation, freeze and restart.
// Optional high-score register enabled by defining SCORE_HIGH_SCORE_EN.
module score_counter
    import score_pkg::*;
#(
    parameter int MAX_SCORE         = DEF_MAX_SCORE,
    parameter int HOLD_DELAY_FRAMES = DEF_HOLD_DELAY_FRAMES,
    parameter int REPEAT_FRAMES     = DEF_REPEAT_FRAMES
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_tick,
    input  logic               i_move_btn,
    input  logic               i_game_over,
    input  logic               i_restart,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic               o_score_max
);
    localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W:0]   MAX_W     = {1'b0, MAX_S};
    localparam logic [FCNT_W-1:0]  HOLD_LAST = FCNT_W'(HOLD_DELAY_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  REP_LAST  = FCNT_W'(REPEAT_FRAMES - 1);

    score_state_t       state, state_n;
    logic [FCNT_W-1:0]  fcnt, fcnt_n;
    logic               btn_s, rise;
    logic               pending, pend_set, commit;
    logic [SCORE_W:0]   score_inc;
    logic [SCORE_W-1:0] score_sat;

    btn_sync u_btn_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_move_btn),
        .o_level (btn_s),
        .o_rise  (rise)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        pend_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    pend_set = 1'b1;
                    fcnt_n   = '0;
                    state_n  = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!btn_s) begin
                    state_n = S_IDLE;
                end else if (i_frame_tick) begin
                    if (fcnt == HOLD_LAST) begin
                        pend_set = 1'b1;
                        fcnt_n   = '0;
                        state_n  = S_REPEAT;
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
            S_REPEAT: begin
                if (!btn_s) begin
                    state_n = S_IDLE;
                end else if (i_frame_tick) begin
                    if (fcnt == REP_LAST) begin
                        pend_set = 1'b1;
                        fcnt_n   = '0;
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
            // Only reached with game over released; a held button still needs a fresh press.
            S_FROZEN: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (i_game_over) begin
            state_n  = S_FROZEN;
            pend_set = 1'b0;
        end
        if (i_restart) begin
            state_n  = S_IDLE;
            fcnt_n   = '0;
            pend_set = 1'b0;
        end
    end

    assign commit    = i_frame_tick & pending;
    assign score_inc = {1'b0, o_score} + 1'b1;
    assign score_sat = (score_inc > MAX_W) ? MAX_S : score_inc[SCORE_W-1:0];

    // A set landing on the commit cycle keeps pending high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fcnt    <= '0;
            pending <= 1'b0;
            o_score <= '0;
        end else begin
            fcnt <= fcnt_n;
            if (i_restart) begin
                pending <= 1'b0;
                o_score <= '0;
            end else if (i_game_over) begin
                pending <= 1'b0;
            end else begin
                pending <= pend_set | (pending & ~commit);
                if (commit) o_score <= score_sat;
            end
        end
    end

    assign o_score_max = (o_score == MAX_S);

`ifdef SCORE_HIGH_SCORE_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                  o_high_score <= '0;
        else if (o_score > o_high_score) o_high_score <= o_score;
    end
`else
    assign o_high_score = '0;
`endif
endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: directed scenarios plus a random run
// compared against a tick-counting reference model.
module tb_score_counter;
    localparam int MAXS   = 99;
    localparam int HOLD   = 3;
    localparam int REP    = 2;
    localparam int TICK_P = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn = 1'b0;
    logic       game_over = 1'b0;
    logic       restart = 1'b0;
    logic [6:0] score, high_score;
    logic       score_max;

    int checks = 0;
    int passed = 0;
    int hold_pts [10] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};

    score_counter #(
        .MAX_SCORE         (MAXS),
        .HOLD_DELAY_FRAMES (HOLD),
        .REPEAT_FRAMES     (REP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (tick),
        .i_move_btn   (btn),
        .i_game_over  (game_over),
        .i_restart    (restart),
        .o_score      (score),
        .o_high_score (high_score),
        .o_score_max  (score_max)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_P - 1) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Reference model: points come from counting held ticks since the press.
    logic m_b1, m_b2, m_q, m_armed, m_held, m_pend, m_frz, m_rise, m_set, m_commit;
    logic n_b1, n_b2, n_q, n_armed, n_held, n_pend, n_frz;
    int   m_n, m_score, m_hs, n_n, n_score, n_hs;

    always_comb begin
        m_rise   = m_b2 & ~m_q & m_armed;
        m_set    = 1'b0;
        m_commit = 1'b0;
        n_b1     = btn;
        n_b2     = m_b1;
        n_q      = m_b2;
        n_armed  = m_armed | ~btn;
        n_held   = m_held;
        n_n      = m_n;
        n_pend   = m_pend;
        n_score  = m_score;
        n_frz    = m_frz;
        n_hs     = (m_score > m_hs) ? m_score : m_hs;
        if (restart) begin
            n_score = 0; n_pend = 1'b0; n_held = 1'b0; n_frz = 1'b0;
        end else if (game_over) begin
            n_frz = 1'b1; n_pend = 1'b0; n_held = 1'b0;
        end else if (m_frz) begin
            n_frz = 1'b0;
        end else begin
            if (!m_held) begin
                if (m_rise) begin
                    m_set = 1'b1; n_held = 1'b1; n_n = 0;
                end
            end else if (!m_b2) begin
                n_held = 1'b0;
            end else if (tick) begin
                n_n = m_n + 1;
                if (n_n >= HOLD && (n_n - HOLD) % REP == 0) m_set = 1'b1;
            end
            m_commit = tick & m_pend;
            if (m_commit) n_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
            n_pend = m_set | (m_pend & ~m_commit);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_b1 <= 1'b0; m_b2 <= 1'b0; m_q <= 1'b0; m_armed <= 1'b0;
            m_held <= 1'b0; m_pend <= 1'b0; m_frz <= 1'b0;
            m_n <= 0; m_score <= 0; m_hs <= 0;
        end else begin
            m_b1 <= n_b1; m_b2 <= n_b2; m_q <= n_q; m_armed <= n_armed;
            m_held <= n_held; m_pend <= n_pend; m_frz <= n_frz;
            m_n <= n_n; m_score <= n_score; m_hs <= n_hs;
        end
    end

    function automatic logic [6:0] hs_after(input int v);
`ifdef SCORE_HIGH_SCORE_EN
        return 7'(v);
`else
        return 7'(v * 0);
`endif
    endfunction

    function automatic logic [14:0] exp_out();
        return {7'(m_score), 1'(m_score == MAXS), hs_after(m_hs)};
    endfunction

    // Returns at the negedge just after a frame tick has been sampled.
    task automatic align();
        int k = 0;
        @(negedge clk);
        while (!tick && k < 2 * TICK_P) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({score, score_max, high_score} !== 15'd0) $display("FAIL reset_hold got %h want 0", {score, score_max, high_score});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({score, score_max, high_score} !== exp_out() || score !== 7'd0) $display("FAIL reset_release got %h want %h", {score, score_max, high_score}, exp_out());
        else passed++;
    endtask

    task automatic test_single();
        bit seen = 1'b0;
        int k = 0;
        align();
        repeat ($urandom_range(0, 40)) @(negedge clk);
        btn = 1'b1;
        while (!seen && k < 2 * TICK_P) begin
            @(negedge clk);
            k++;
            if (tick) seen = 1'b1;
            checks++;
            if (score !== 7'd0) $display("FAIL single_before_tick got %0d want 0", score);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (score !== 7'd1) $display("FAIL single_after_tick got %0d want 1", score);
        else passed++;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        btn = 1'b0;
        align();
        align();
        checks++;
        if (score !== 7'd1) $display("FAIL single_once got %0d want 1", score);
        else passed++;
    endtask

    task automatic test_latency();
        pulse_restart();
        align();
        repeat (96) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (score !== 7'd0) $display("FAIL latency_pre got %0d want 0", score);
        else passed++;
        @(negedge clk);
        checks++;
        if (score !== 7'd1) $display("FAIL latency_hit got %0d want 1", score);
        else passed++;
        repeat (4) @(negedge clk);
        btn = 1'b0;
        align();
        repeat (97) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (score !== 7'd1) $display("FAIL latency_miss got %0d want 1", score);
        else passed++;
        btn = 1'b0;
        align();
        checks++;
        if (score !== 7'd2) $display("FAIL latency_next got %0d want 2", score);
        else passed++;
    endtask

    task automatic test_hold();
        pulse_restart();
        align();
        repeat ($urandom_range(0, 60)) @(negedge clk);
        btn = 1'b1;
        for (int t = 0; t < 10; t++) begin
            align();
            checks++;
            if (score !== 7'(hold_pts[t])) $display("FAIL hold_tick%0d got %0d want %0d", t + 1, score, hold_pts[t]);
            else passed++;
        end
        btn = 1'b0;
    endtask

    task automatic test_saturation();
        pulse_restart();
        align();
        for (int i = 0; i < 98; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            btn = 1'b1;
            repeat ($urandom_range(4, 12)) @(negedge clk);
            btn = 1'b0;
            align();
            checks++;
            if (score !== 7'(i + 1)) $display("FAIL preload_%0d got %0d want %0d", i, score, i + 1);
            else passed++;
        end
        checks++;
        if (score_max !== 1'b0) $display("FAIL max_at_98 got %b want 0", score_max);
        else passed++;
        btn = 1'b1;
        for (int t = 0; t < 6; t++) begin
            align();
            checks++;
            if ({score, score_max} !== {7'd99, 1'b1}) $display("FAIL saturate_tick%0d got %0d/%b want 99/1", t + 1, score, score_max);
            else passed++;
        end
        btn = 1'b0;
    endtask

    task automatic test_game_over();
        pulse_restart();
        align();
        repeat ($urandom_range(0, 60)) @(negedge clk);
        btn = 1'b1;
        repeat (14) align();
        checks++;
        if (score !== 7'd7) $display("FAIL game_over_preload got %0d want 7", score);
        else passed++;
        repeat (37) @(negedge clk);
        game_over = 1'b1;
        for (int t = 0; t < 10; t++) begin
            align();
            checks++;
            if (score !== 7'd7) $display("FAIL frozen_tick%0d got %0d want 7", t + 1, score);
            else passed++;
        end
    endtask

    task automatic test_restart();
        repeat ($urandom_range(10, 50)) @(negedge clk);
        game_over = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (score !== 7'd0) $display("FAIL restart_score got %0d want 0", score);
        else passed++;
        checks++;
        if (high_score !== hs_after(7)) $display("FAIL restart_high got %0d want %0d", high_score, hs_after(7));
        else passed++;
        for (int t = 0; t < 4; t++) begin
            align();
            checks++;
            if (score !== 7'd0) $display("FAIL restart_held_tick%0d got %0d want 0", t + 1, score);
            else passed++;
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        align();
        checks++;
        if (score !== 7'd1) $display("FAIL restart_repress got %0d want 1", score);
        else passed++;
    endtask

    task automatic test_reset_collapse();
        pulse_restart();
        align();
        btn = 1'b1;
        repeat (6) align();
        repeat ($urandom_range(10, 60)) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({score, score_max, high_score} !== 15'd0) $display("FAIL midhold_reset got %h want 0", {score, score_max, high_score});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            align();
            checks++;
            if (score !== 7'd0) $display("FAIL reset_held_tick%0d got %0d want 0", t + 1, score);
            else passed++;
        end
        btn = 1'b0;
        align();
        repeat (10) @(negedge clk);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        repeat (5) @(negedge clk);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        align();
        checks++;
        if (score !== 7'd1) $display("FAIL collapse got %0d want 1", score);
        else passed++;
        align();
        checks++;
        if (score !== 7'd1) $display("FAIL collapse_stable got %0d want 1", score);
        else passed++;
    endtask

    task automatic test_random();
        pulse_restart();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            checks++;
            if ({score, score_max, high_score} !== exp_out()) $display("FAIL random_c%0d got %h want %h", c, {score, score_max, high_score}, exp_out());
            else passed++;
            if ($urandom_range(0, 29) == 0) btn = ~btn;
            if ($urandom_range(0, 399) == 0) game_over = ~game_over;
            restart = ($urandom_range(0, 499) == 0);
            rst_n = ($urandom_range(0, 1999) != 0);
        end
        restart = 1'b0;
        rst_n = 1'b1;
        game_over = 1'b0;
        btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_hold();
        test_saturation();
        test_game_over();
        test_restart();
        test_reset_collapse();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
